// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register unit for a MIPS-style pipeline.
//   Multiplies internally using a 32-iteration shift-add followed by one sign-fix
//   cycle. Divides through an external divider handshake, with a timeout and an
//   abort phase. MTHI/MTLO write HI/LO directly and never stall.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_op_valid, i_op        operation request and code
//                           (000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO)
//   i_op_a, i_op_b          rs / rt operands
//   i_flush                 pipeline kill
//   o_busy                  unit not idle (combinational from state)
//   o_hi, o_lo              architectural HI / LO
//   o_err                   one-cycle pulse on divide timeout
//   o_div_fg/sg/wrp         divider request, signed select, abort
//   o_div_a, o_div_b        divider dividend / divisor
//   i_div_fin, i_div_result divider done and {remainder, quotient}
module hilo_unit #(
    parameter int unsigned DIV_TIMEOUT = 63
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_err,
    output logic        o_div_fg,
    output logic        o_div_sg,
    output logic        o_div_wrp,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    input  logic        i_div_fin,
    input  logic [63:0] i_div_result
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivWait,
        StDivRel,
        StAbort
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic        r_err, w_err_nxt;
    logic        r_div_fg, w_div_fg_nxt;
    logic        r_div_sg, w_div_sg_nxt;
    logic        r_div_wrp, w_div_wrp_nxt;
    logic [31:0] r_div_a, w_div_a_nxt;
    logic [31:0] r_div_b, w_div_b_nxt;
    logic [31:0] r_ma, w_ma_nxt;        // multiplicand magnitude
    logic [31:0] r_mb, w_mb_nxt;        // multiplier magnitude, consumed LSB first
    logic        r_msign, w_msign_nxt;  // sign of the final product
    logic [63:0] r_prod, w_prod_nxt;
    logic [5:0]  r_mcnt, w_mcnt_nxt;
    logic [31:0] r_tcnt, w_tcnt_nxt;
    logic        r_acnt, w_acnt_nxt;

    logic        w_mul_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic [63:0] w_prod_neg;
    logic [31:0] w_tcnt_inc;

    assign w_mul_signed = (i_op == OpMult);
    assign w_abs_a      = (w_mul_signed && i_op_a[31]) ? (~i_op_a + 32'd1) : i_op_a;
    assign w_abs_b      = (w_mul_signed && i_op_b[31]) ? (~i_op_b + 32'd1) : i_op_b;
    // Accumulate into the upper half, then shift the whole product right one bit.
    assign w_addend     = r_mb[0] ? r_ma : 32'd0;
    assign w_sum        = {1'b0, r_prod[63:32]} + {1'b0, w_addend};
    assign w_prod_neg   = ~r_prod + 64'd1;
    assign w_tcnt_inc   = r_tcnt + 32'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_err_nxt     = 1'b0;
        w_div_fg_nxt  = r_div_fg;
        w_div_sg_nxt  = r_div_sg;
        w_div_wrp_nxt = r_div_wrp;
        w_div_a_nxt   = r_div_a;
        w_div_b_nxt   = r_div_b;
        w_ma_nxt      = r_ma;
        w_mb_nxt      = r_mb;
        w_msign_nxt   = r_msign;
        w_prod_nxt    = r_prod;
        w_mcnt_nxt    = r_mcnt;
        w_tcnt_nxt    = r_tcnt;
        w_acnt_nxt    = r_acnt;

        unique case (r_state)
            StIdle: begin
                if (i_op_valid && !i_flush) begin
                    case (i_op)
                        OpMult, OpMultu: begin
                            w_ma_nxt    = w_abs_a;
                            w_mb_nxt    = w_abs_b;
                            w_msign_nxt = w_mul_signed & (i_op_a[31] ^ i_op_b[31]);
                            w_prod_nxt  = 64'd0;
                            w_mcnt_nxt  = 6'd0;
                            w_state_nxt = StMul;
                        end
                        OpDiv, OpDivu: begin
                            w_div_a_nxt  = i_op_a;
                            w_div_b_nxt  = i_op_b;
                            w_div_sg_nxt = (i_op == OpDiv);
                            w_div_fg_nxt = 1'b1;
                            w_tcnt_nxt   = 32'd0;
                            w_state_nxt  = StDivWait;
                        end
                        OpMthi:  w_hi_nxt = i_op_a;
                        OpMtlo:  w_lo_nxt = i_op_a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (i_flush) begin
                    w_prod_nxt  = 64'd0;
                    w_state_nxt = StIdle;
                end else if (r_mcnt == 6'd32) begin
                    // Sign-fix cycle doubles as write-back.
                    {w_hi_nxt, w_lo_nxt} = r_msign ? w_prod_neg : r_prod;
                    w_state_nxt          = StIdle;
                end else begin
                    w_prod_nxt = {w_sum, r_prod[31:1]};
                    w_mb_nxt   = r_mb >> 1;
                    w_mcnt_nxt = r_mcnt + 6'd1;
                end
            end
            StDivWait: begin
                // Flush wins over a coincident div_fin; the result is dropped.
                if (i_flush) begin
                    w_div_fg_nxt  = 1'b0;
                    w_div_wrp_nxt = 1'b1;
                    w_acnt_nxt    = 1'b0;
                    w_state_nxt   = StAbort;
                end else if (i_div_fin) begin
                    w_hi_nxt     = i_div_result[63:32];
                    w_lo_nxt     = i_div_result[31:0];
                    w_div_fg_nxt = 1'b0;
                    w_state_nxt  = StDivRel;
                end else if (w_tcnt_inc >= DIV_TIMEOUT) begin
                    w_err_nxt     = 1'b1;
                    w_div_fg_nxt  = 1'b0;
                    w_div_wrp_nxt = 1'b1;
                    w_acnt_nxt    = 1'b0;
                    w_state_nxt   = StAbort;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
            end
            StDivRel: begin
                w_state_nxt = StIdle;
            end
            StAbort: begin
                if (r_acnt) begin
                    w_div_wrp_nxt = 1'b0;
                    w_state_nxt   = StIdle;
                end else begin
                    w_acnt_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_err     <= 1'b0;
            r_div_fg  <= 1'b0;
            r_div_sg  <= 1'b0;
            r_div_wrp <= 1'b0;
            r_div_a   <= 32'd0;
            r_div_b   <= 32'd0;
            r_ma      <= 32'd0;
            r_mb      <= 32'd0;
            r_msign   <= 1'b0;
            r_prod    <= 64'd0;
            r_mcnt    <= 6'd0;
            r_tcnt    <= 32'd0;
            r_acnt    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_err     <= w_err_nxt;
            r_div_fg  <= w_div_fg_nxt;
            r_div_sg  <= w_div_sg_nxt;
            r_div_wrp <= w_div_wrp_nxt;
            r_div_a   <= w_div_a_nxt;
            r_div_b   <= w_div_b_nxt;
            r_ma      <= w_ma_nxt;
            r_mb      <= w_mb_nxt;
            r_msign   <= w_msign_nxt;
            r_prod    <= w_prod_nxt;
            r_mcnt    <= w_mcnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_acnt    <= w_acnt_nxt;
        end
    end

    assign o_busy    = (r_state != StIdle);
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
    assign o_err     = r_err;
    assign o_div_fg  = r_div_fg;
    assign o_div_sg  = r_div_sg;
    assign o_div_wrp = r_div_wrp;
    assign o_div_a   = r_div_a;
    assign o_div_b   = r_div_b;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit.
//   dut    : default DIV_TIMEOUT, attached to a behavioural divider with programmable latency.
//   dut_to : DIV_TIMEOUT=4, divider never finishes; used for the timeout sequence only.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_valid2;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        busy, err, div_fg, div_sg, div_wrp;
    logic [31:0] hi, lo, div_a, div_b;
    logic        div_fin = 1'b0;
    logic [63:0] div_result = 64'd0;

    logic        t_busy, t_err, t_div_fg, t_div_sg, t_div_wrp;
    logic [31:0] t_hi, t_lo, t_div_a, t_div_b;

    int n_chk = 0;
    int n_err = 0;
    int div_lat = 2;
    int div_cnt = 0;
    logic div_en = 1'b1;

    always #5 clk = ~clk;

    hilo_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op(op),
        .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush), .o_busy(busy),
        .o_hi(hi), .o_lo(lo), .o_err(err), .o_div_fg(div_fg), .o_div_sg(div_sg),
        .o_div_wrp(div_wrp), .o_div_a(div_a), .o_div_b(div_b),
        .i_div_fin(div_fin), .i_div_result(div_result)
    );

    hilo_unit #(.DIV_TIMEOUT(4)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid2), .i_op(op),
        .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush), .o_busy(t_busy),
        .o_hi(t_hi), .o_lo(t_lo), .o_err(t_err), .o_div_fg(t_div_fg), .o_div_sg(t_div_sg),
        .o_div_wrp(t_div_wrp), .o_div_a(t_div_a), .o_div_b(t_div_b),
        .i_div_fin(1'b0), .i_div_result(64'd0)
    );

    // Reference arithmetic: MIPS semantics, plain integer math.
    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Returns {remainder, quotient}; zero divisor yields zeros.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // External divider: raises fin for one cycle after div_lat cycles of request.
    always @(posedge clk) begin
        div_fin <= 1'b0;
        if (div_fg && !div_fin) begin
            if (div_en && (div_cnt + 1 >= div_lat)) begin
                div_fin    <= 1'b1;
                div_result <= ref_div(div_sg, div_a, div_b);
                div_cnt    <= 0;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end else if (!div_fg) begin
            div_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents one op for one edge and returns at the next negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        issue(o, a, b);
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vec[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          cyc, exp_cyc, k;
        logic [2:0]  ro;
        logic [31:0] ra, rb, m_hi, m_lo;
        logic        bad;

        vec[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vec[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vec[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vec[3]  = '{3'b000, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 33};
        vec[4]  = '{3'b001, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 33};
        vec[5]  = '{3'b101, 32'h12345678, 32'd0,        32'h00000000, 32'h12345678, 0};
        vec[6]  = '{3'b100, 32'hCAFEBABE, 32'd0,        32'hCAFEBABE, 32'h12345678, 0};
        vec[7]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vec[8]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 4};
        vec[9]  = '{3'b011, 32'd100,      32'd0,        32'h00000000, 32'h00000000, 4};
        vec[10] = '{3'b011, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 4};

        rst_n = 1'b0; op_valid = 1'b0; op_valid2 = 1'b0; op = 3'd0;
        op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
        #1;
        chk("reset_hilo", {hi, lo}, 128'd0);
        chk("reset_ctrl", {busy, err, div_fg, div_sg, div_wrp, div_a, div_b}, 128'd0);
        chk("reset_to", {t_busy, t_err, t_div_fg, t_div_wrp, t_hi, t_lo}, 128'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors; DIV rows use a 2-cycle divider: 3 request cycles + 1 release.
        div_lat = 2;
        for (int i = 0; i < 11; i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, cyc);
            chk($sformatf("vec%0d_hi", i), hi, vec[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vec[i].lo);
            chk($sformatf("vec%0d_busy_cycles", i), cyc, vec[i].cyc);
        end

        // DIV with a 34-cycle divider: request held until fin, then one release cycle.
        div_lat = 34;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        chk("div_operands", {div_sg, div_a, div_b}, {1'b1, 32'hFFFFFFF9, 32'd2});
        cyc = 0;
        bad = 1'b0;
        while (div_fg && cyc < 200) begin
            if ({div_sg, div_a, div_b} !== {1'b1, 32'hFFFFFFF9, 32'd2}) bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        chk("div_operands_stable", bad, 1'b0);
        chk("div_fg_hold", cyc, 35);
        chk("div_rel", {busy, div_fg, hi, lo}, {1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        @(negedge clk);
        chk("div_rel_end", busy, 1'b0);

        // DIVU flushed 5 cycles after accept.
        run_op(3'b100, 32'h11112222, 32'd0, cyc);
        run_op(3'b101, 32'h33334444, 32'd0, cyc);
        div_en = 1'b0;
        issue(3'b011, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush5_abort", {busy, err, div_fg, div_wrp}, 4'b1001);
        @(negedge clk);
        chk("flush5_wrp2", {busy, div_wrp}, 2'b11);
        @(negedge clk);
        chk("flush5_idle", {busy, div_wrp, hi, lo}, {2'b00, 32'h11112222, 32'h33334444});

        // DIVU with flush on the same edge as div_fin.
        div_en = 1'b1;
        div_lat = 3;
        issue(3'b011, 32'd100, 32'd7);
        cyc = 0;
        while (!div_fin && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("fin_seen", div_fin, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("finflush_abort", {busy, div_fg, div_wrp, hi, lo},
            {3'b101, 32'h11112222, 32'h33334444});
        @(negedge clk);
        chk("finflush_wrp2", {busy, div_wrp}, 2'b11);
        @(negedge clk);
        chk("finflush_idle", {busy, div_wrp, hi, lo}, {2'b00, 32'h11112222, 32'h33334444});

        // Flush mid-MUL: no write-back, now or later.
        issue(3'b000, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("mul_flush", {busy, hi, lo}, {1'b0, 32'h11112222, 32'h33334444});
        repeat (40) @(negedge clk);
        chk("mul_flush_late", {busy, hi, lo}, {1'b0, 32'h11112222, 32'h33334444});

        // Flush in IDLE blocks MTHI; ignored opcode leaves state alone.
        op_valid = 1'b1; op = 3'b100; op_a = 32'hDEADBEEF; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_mthi", {busy, hi}, {1'b0, 32'h11112222});
        run_op(3'b110, 32'h55555555, 32'h2, cyc);
        chk("ignored_op", {32'(cyc), hi, lo}, {32'd0, 32'h11112222, 32'h33334444});

        // op_valid while busy is ignored.
        issue(3'b000, 32'd3, 32'd5);
        op_valid = 1'b1; op = 3'b100; op_a = 32'hDEADBEEF;
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_ignores_op", {hi, lo}, {32'd0, 32'd15});

        // Timeout on the DIV_TIMEOUT=4 instance.
        op = 3'b010; op_a = 32'd55; op_b = 32'd3; op_valid2 = 1'b1;
        @(negedge clk);
        op_valid2 = 1'b0;
        chk("to_operands", {t_div_sg, t_div_a, t_div_b}, {1'b1, 32'd55, 32'd3});
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_wait%0d", i), {t_err, t_div_fg, t_div_wrp, t_busy}, 4'b0101);
            @(negedge clk);
        end
        chk("to_err", {t_err, t_div_fg, t_div_wrp, t_busy}, 4'b1011);
        @(negedge clk);
        chk("to_abort2", {t_err, t_div_fg, t_div_wrp, t_busy}, 4'b0011);
        @(negedge clk);
        chk("to_idle", {t_err, t_div_fg, t_div_wrp, t_busy, t_hi, t_lo}, 68'd0);

        // Asynchronous reset mid-MUL, op held across reset, accepted after release.
        run_op(3'b100, 32'hA5A5A5A5, 32'd0, cyc);
        issue(3'b000, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        op_valid = 1'b1; op = 3'b100; op_a = 32'h77;
        #1;
        chk("async_rst_hilo", {hi, lo}, 128'd0);
        chk("async_rst_ctrl", {busy, err, div_fg, div_sg, div_wrp, div_a, div_b}, 128'd0);
        @(negedge clk);
        chk("rst_blocks_op", hi, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        chk("first_op_after_rst", {busy, hi}, {1'b0, 32'h77});
        repeat (40) @(negedge clk);
        chk("no_mul_wb_after_rst", {busy, lo}, 33'd0);

        // Asynchronous reset mid-DIV.
        div_lat = 20;
        issue(3'b010, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_div", {busy, div_fg, div_sg, hi, lo}, 67'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_div_wb_after_rst", {busy, div_fg, hi, lo}, 66'd0);

        // Randomized ops against the arithmetic model.
        m_hi = hi;
        m_lo = lo;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 6);
            ro = (k == 6) ? (($urandom_range(0, 1) == 1) ? 3'b111 : 3'b110) : 3'(k);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            div_lat = $urandom_range(1, 6);
            exp_cyc = 0;
            case (ro)
                3'b000: begin {m_hi, m_lo} = ref_mul(1'b1, ra, rb); exp_cyc = 33; end
                3'b001: begin {m_hi, m_lo} = ref_mul(1'b0, ra, rb); exp_cyc = 33; end
                3'b010: begin {m_hi, m_lo} = ref_div(1'b1, ra, rb); exp_cyc = div_lat + 2; end
                3'b011: begin {m_hi, m_lo} = ref_div(1'b0, ra, rb); exp_cyc = div_lat + 2; end
                3'b100: m_hi = ra;
                3'b101: m_lo = ra;
                default: ;
            endcase
            run_op(ro, ra, rb, cyc);
            chk($sformatf("rnd%0d_op%0d", i, ro), {32'(cyc), hi, lo}, {32'(exp_cyc), m_hi, m_lo});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
